// File: rtl/hazard_unit_if.sv
// Hazard unit bus: pipeline-side hazard inputs and the stall/flush controls.
// The pipeline (master) drives the stage snapshots; the hazard unit (slave)
// drives Pause, Flush and the status outputs.
interface hazard_unit_if #(
    parameter int ADDR_W = 5
);
    logic              MEM_memRead;
    logic              MEM_ioRead;
    logic [ADDR_W-1:0] MEM_rd_addr;
    logic [ADDR_W-1:0] EX_rs1_addr;
    logic [ADDR_W-1:0] EX_rs2_addr;
    logic              EX_rs1_used;
    logic              EX_rs2_used;
    logic              EX_branch_taken;
    logic              Pause;
    logic              Flush;
    logic              stall_busy;
    logic [31:0]       stall_cycles;

    modport master (
        output MEM_memRead, MEM_ioRead, MEM_rd_addr,
        output EX_rs1_addr, EX_rs2_addr, EX_rs1_used, EX_rs2_used,
        output EX_branch_taken,
        input  Pause, Flush, stall_busy, stall_cycles
    );

    modport slave (
        input  MEM_memRead, MEM_ioRead, MEM_rd_addr,
        input  EX_rs1_addr, EX_rs2_addr, EX_rs1_used, EX_rs2_used,
        input  EX_branch_taken,
        output Pause, Flush, stall_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard unit for a 5-stage pipeline.
// Detects a load/IO-read in MEM feeding a source register of EX and pauses
// the front of the pipe for MEM_STALL or IO_STALL cycles (the first cycle is
// raised combinationally from IDLE, the rest come from the STALL state).
// A taken branch in EX is flushed only once the pause has cleared, because
// its operands are stale while the hazard is pending.
// Optional feature: define HAZARD_UNIT_STAT_EN to enable the saturating
// stall_cycles counter; otherwise stall_cycles is tied to zero.
module hazard_unit #(
    parameter int ADDR_W    = 5,
    parameter int MEM_STALL = 1,
    parameter int IO_STALL  = 3
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic [3:0] MEM_LEN = 4'(MEM_STALL);
    localparam logic [3:0] IO_LEN  = 4'(IO_STALL);

    logic [0:0] r_state;
    logic [3:0] r_count;

    logic       w_load_hit;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_hazard;
    logic [3:0] w_len;
    logic       w_pause;

    // Register 0 is hard-wired zero, so a write to it can never be a producer.
    assign w_load_hit = (bus.MEM_memRead | bus.MEM_ioRead) &
                        (bus.MEM_rd_addr != '0);
    assign w_rs1_hit  = bus.EX_rs1_used & (bus.EX_rs1_addr == bus.MEM_rd_addr);
    assign w_rs2_hit  = bus.EX_rs2_used & (bus.EX_rs2_addr == bus.MEM_rd_addr);
    assign w_hazard   = w_load_hit & (w_rs1_hit | w_rs2_hit);

    // IO reads are slower than memory loads, so IO wins when both are flagged.
    assign w_len = bus.MEM_ioRead ? IO_LEN : MEM_LEN;

    // The first pause cycle comes straight from IDLE; STALL supplies the rest.
    assign w_pause = ~rst & ((r_state == ST_STALL) |
                             ((r_state == ST_IDLE) & w_hazard));

    assign bus.Pause      = w_pause;
    assign bus.stall_busy = ~rst & (r_state == ST_STALL);
    assign bus.Flush      = ~rst & bus.EX_branch_taken & ~w_pause;

    // Stall FSM: IDLE arms the down-counter with L-2, STALL ends on count 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hazard && (w_len > 4'd1)) begin
                        r_count <= w_len - 4'd2;
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    // New hazards are ignored here; the stall is never extended.
                    if (r_count == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_UNIT_STAT_EN
    logic [31:0] r_stall_cycles;

    // Count every paused edge, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_pause && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = rst ? '0 : r_stall_cycles;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit. Two instances share one stimulus stream:
// dut_a uses MEM_STALL=1/IO_STALL=3, dut_b uses MEM_STALL=2/IO_STALL=3.
// The driver pushes hand-computed expectations per cycle; a monitor on the
// falling edge pops and compares them.
module tb_hazard_unit;

    localparam int ADDR_W = 5;

    typedef struct {
        string       name;
        logic        pa, ba, fa;
        logic        pb, bb, fb;
        logic [31:0] ca, cb;
    } exp_t;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;

    hazard_unit_if #(.ADDR_W(ADDR_W)) ifa ();
    hazard_unit_if #(.ADDR_W(ADDR_W)) ifb ();

    hazard_unit #(.ADDR_W(ADDR_W), .MEM_STALL(1), .IO_STALL(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    hazard_unit #(.ADDR_W(ADDR_W), .MEM_STALL(2), .IO_STALL(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input bit mr, input bit ior, input int rd,
                              input int rs1, input int rs2, input bit u1,
                              input bit u2, input bit br);
        ifa.MEM_memRead     = mr;
        ifa.MEM_ioRead      = ior;
        ifa.MEM_rd_addr     = ADDR_W'(rd);
        ifa.EX_rs1_addr     = ADDR_W'(rs1);
        ifa.EX_rs2_addr     = ADDR_W'(rs2);
        ifa.EX_rs1_used     = u1;
        ifa.EX_rs2_used     = u2;
        ifa.EX_branch_taken = br;
        ifb.MEM_memRead     = mr;
        ifb.MEM_ioRead      = ior;
        ifb.MEM_rd_addr     = ADDR_W'(rd);
        ifb.EX_rs1_addr     = ADDR_W'(rs1);
        ifb.EX_rs2_addr     = ADDR_W'(rs2);
        ifb.EX_rs1_used     = u1;
        ifb.EX_rs2_used     = u2;
        ifb.EX_branch_taken = br;
    endtask

    // One cycle of stimulus plus the expected Pause/stall_busy of each DUT.
    task automatic vec(input string name, input bit r, input bit mr,
                       input bit ior, input int rd, input int rs1,
                       input int rs2, input bit u1, input bit u2,
                       input bit br, input bit pa, input bit ba,
                       input bit pb, input bit bb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        set_inputs(mr, ior, rd, rs1, rs2, u1, u2, br);
        e.name = name;
        e.pa = pa;
        e.ba = ba;
        e.fa = !r && br && !pa;
        e.pb = pb;
        e.bb = bb;
        e.fb = !r && br && !pb;
`ifdef HAZARD_UNIT_STAT_EN
        e.ca = r ? 32'd0 : cnt_a;
        e.cb = r ? 32'd0 : cnt_b;
        if (r) begin
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (pa) cnt_a++;
            if (pb) cnt_b++;
        end
`else
        e.ca = 32'd0;
        e.cb = 32'd0;
`endif
        sb.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "/a.Pause"},        32'(ifa.Pause),      32'(e.pa));
            check({e.name, "/a.stall_busy"},   32'(ifa.stall_busy), 32'(e.ba));
            check({e.name, "/a.Flush"},        32'(ifa.Flush),      32'(e.fa));
            check({e.name, "/a.stall_cycles"}, ifa.stall_cycles,    e.ca);
            check({e.name, "/b.Pause"},        32'(ifb.Pause),      32'(e.pb));
            check({e.name, "/b.stall_busy"},   32'(ifb.stall_busy), 32'(e.bb));
            check({e.name, "/b.Flush"},        32'(ifb.Flush),      32'(e.fb));
            check({e.name, "/b.stall_cycles"}, ifb.stall_cycles,    e.cb);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset holds everything low even with a hazard and branch present.
        vec("rst_hold", 1, 1, 0, 5, 5, 0, 1, 0, 1,  0, 0, 0, 0);
        vec("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Memory load-use on rs1: a pauses 1 cycle, b pauses 2.
        vec("mem_c1",   0, 1, 0, 5, 5, 0, 1, 0, 0,  1, 0, 1, 0);
        vec("mem_c2",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
        vec("mem_c3",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // No hazard: x0 destination, unused sources, mismatched register.
        vec("rd_zero",  0, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0);
        vec("unused",   0, 1, 0, 9, 9, 9, 0, 0, 0,  0, 0, 0, 0);
        vec("nomatch",  0, 0, 1, 9, 8, 10, 1, 1, 0, 0, 0, 0, 0);

        // IO read on rs2: 3 cycles; hazard held during STALL is ignored.
        vec("io_c1",    0, 0, 1, 7, 0, 7, 0, 1, 0,  1, 0, 1, 0);
        vec("io_c2",    0, 0, 1, 7, 0, 7, 0, 1, 0,  1, 1, 1, 1);
        vec("io_c3",    0, 0, 1, 7, 0, 7, 0, 1, 0,  1, 1, 1, 1);
        vec("io_c4",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Both reads and both sources match: single IO-length stall.
        vec("both_c1",  0, 1, 1, 3, 3, 3, 1, 1, 0,  1, 0, 1, 0);
        vec("both_c2",  0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
        vec("both_c3",  0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
        vec("both_c4",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Hazard with a taken branch held 3 cycles: flush waits for Pause.
        vec("br_c1",    0, 1, 0, 4, 4, 0, 1, 0, 1,  1, 0, 1, 0);
        vec("br_c2",    0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1);
        vec("br_c3",    0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);

        // Consecutive memory hazards: a retriggers, b ignores while stalled.
        vec("mb2b_c1",  0, 1, 0, 2, 0, 2, 0, 1, 0,  1, 0, 1, 0);
        vec("mb2b_c2",  0, 1, 0, 2, 0, 2, 0, 1, 0,  1, 0, 1, 1);
        vec("mb2b_c3",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Back-to-back IO hazards: six gapless pause cycles.
        vec("iob2b_c1", 0, 0, 1, 7, 7, 0, 1, 0, 0,  1, 0, 1, 0);
        vec("iob2b_c2", 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
        vec("iob2b_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
        vec("iob2b_c4", 0, 0, 1, 7, 7, 0, 1, 0, 0,  1, 0, 1, 0);
        vec("iob2b_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
        vec("iob2b_c6", 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1);
        vec("iob2b_c7", 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Reset in the 2nd cycle of an IO stall aborts it and clears stats.
        vec("rstmid_c1", 0, 0, 1, 6, 6, 0, 1, 0, 0, 1, 0, 1, 0);
        vec("rstmid_c2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("rstmid_c3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("rstmid_c4", 0, 1, 0, 6, 6, 0, 1, 0, 0, 1, 0, 1, 0);
        vec("rstmid_c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vec("rstmid_c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
